// File: rtl/mac_dot_seq_if.sv
// Package and handshake interface for mac_dot_seq.
//
// Verilog_parameter : shared default operand width.
// mac_dot_seq_if    : groups the command, operand-stream and result-stream signals.
//   start/len/bias   - command, sampled when the block is idle
//   in_valid/in_ready, a_in/b_in - operand pair stream
//   out_valid/out_ready, result  - result stream
//   busy             - operation in progress
// Modport master is the producer/consumer side; slave is the MAC block.

package Verilog_parameter;
    parameter int unsigned S = 8;
endpackage

interface mac_dot_seq_if #(
    parameter int unsigned S     = Verilog_parameter::S,
    parameter int unsigned LEN_W = 4,
    localparam int unsigned ACC_W = 2 * S + LEN_W
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [S-1:0]     bias;
    logic             in_valid;
    logic             in_ready;
    logic [S-1:0]     a_in;
    logic [S-1:0]     b_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             busy;

    modport master (
        output start, len, bias, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  start, len, bias, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mac_dot_seq.sv
// Sequential dot-product MAC: result = bias + sum(a_in * b_in) over len operand pairs.
//
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high reset
//   bus   - mac_dot_seq_if.slave (command, operand stream, result stream, busy)
//
// Accumulator is 2*S+LEN_W bits wide, so no operand values or length can overflow it.

module mac_dot_seq #(
    parameter int unsigned S     = Verilog_parameter::S,
    parameter int unsigned LEN_W = 4,
    localparam int unsigned ACC_W = 2 * S + LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    mac_dot_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StOut  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] result_q, result_d;

    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] acc_sum;
    logic             xfer;

    assign prod    = ACC_W'(bus.a_in) * ACC_W'(bus.b_in);
    assign acc_sum = acc_q + prod;
    // in_ready comes from registered state only, so xfer depends on in_valid but not vice versa
    assign xfer    = bus.in_valid && (state_q == StRun);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        acc_d   = ACC_W'(bus.bias);
                        cnt_d   = bus.len;
                        state_d = StRun;
                    end else begin
                        result_d = ACC_W'(bus.bias);
                        state_d  = StOut;
                    end
                end
            end
            StRun: begin
                if (xfer) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        result_d = acc_sum;
                        state_d  = StOut;
                    end
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StRun);
    assign bus.out_valid = (state_q == StOut);
    assign bus.busy      = (state_q == StRun) || (state_q == StOut);
    assign bus.result    = result_q;

endmodule

// File: doc/mac_dot_seq.md
MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

Interface
REQ-001 The module SHALL have parameter S, default imported from package Verilog_parameter (8): operand width.
REQ-002 The module SHALL have parameter LEN_W, default 4: width of the vector-length field.
REQ-003 The module SHALL have derived parameter ACC_W = 2*S+LEN_W: accumulator and result width.
REQ-004 The module SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1: begin a dot-product operation; sampled in IDLE only.
REQ-007 The module SHALL have port len, input, LEN_W: element count, sampled with start.
REQ-008 The module SHALL have port bias, input, S: initial addend C, sampled with start.
REQ-009 The module SHALL have port in_valid, input, 1: an operand pair is present.
REQ-010 The module SHALL have port in_ready, output, 1: the block accepts an operand pair.
REQ-011 The module SHALL have ports a_in and b_in, input, S each: operand pair.
REQ-012 The module SHALL have port out_valid, output, 1: result is valid.
REQ-013 The module SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-014 The module SHALL have port result, output, ACC_W: bias + sum of a_in*b_in, unsigned.
REQ-015 The module SHALL have port busy, output, 1: high in RUN and OUT.

Function
REQ-016 The module SHALL implement states IDLE, RUN and OUT, held in a registered state variable.
REQ-017 In IDLE, start=1 with len!=0 SHALL load acc<=zero-extended bias and cnt<=len, then move to RUN.
REQ-018 In IDLE, start=1 with len==0 SHALL load result<=zero-extended bias, then move to OUT; no operand is consumed.
REQ-019 start SHALL be ignored in RUN and OUT, and len and bias SHALL be ignored when start is not accepted.
REQ-020 in_ready SHALL be 1 exactly when state==RUN, decoded from registered state only and never from in_valid.
REQ-021 A transfer SHALL occur on a cycle with in_valid&in_ready: acc<=acc+a_in*b_in, cnt<=cnt-1.
REQ-022 Cycles in RUN with in_valid=0 SHALL leave acc and cnt unchanged, so input gaps are allowed.
REQ-023 A transfer with cnt==1 SHALL set result<=acc+a_in*b_in and move to OUT; out_valid rises in the next cycle (1-cycle latency from the last transfer).
REQ-024 All arithmetic SHALL be unsigned at ACC_W bits, and the ACC_W sizing guarantees no overflow for any len and operand values.
REQ-025 out_valid SHALL be registered and equal to 1 exactly in OUT.
REQ-026 result SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 out_valid&out_ready SHALL return the block to IDLE in the next cycle, and a new start is accepted no earlier than that IDLE cycle.
REQ-028 result SHALL hold its last value in IDLE and RUN, and is meaningful only while out_valid=1.
REQ-029 busy SHALL be 1 in RUN and OUT and 0 in IDLE.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and clear acc, cnt and result to 0 in every state.
REQ-031 While in reset, in_ready, out_valid and busy SHALL be 0.
REQ-032 Reset during RUN or OUT SHALL abandon the operation with no result delivered; the next operation SHALL be unaffected.
REQ-033 reset SHALL take priority over start, transfers and the output handshake in the same cycle.

Verification
REQ-034 The bench SHALL check reset: assert reset 2 cycles in any state -> out_valid=0, in_ready=0, busy=0, result=0.
REQ-035 The bench SHALL check a basic operation: start, len=3, bias=5, pairs (2,3),(4,5),(1,1) with a 2-cycle in_valid gap -> result=32, out_valid exactly 1 cycle after the 3rd transfer.
REQ-036 The bench SHALL check zero length: start, len=0, bias=7 -> in_ready never 1, out_valid next cycle, result=7.
REQ-037 The bench SHALL check backpressure: out_ready=0 for 4 cycles with start=1 pulsed -> result stable, state OUT kept, start ignored; out_ready=1 -> IDLE next cycle.
REQ-038 The bench SHALL check the maximum case (S=8, LEN_W=4): len=15, every a_in=b_in=255, bias=255 -> result=975630 with no wrap.
REQ-039 The bench SHALL check reset mid-operation: reset after 2 of 4 transfers, then start, len=1, bias=0, pair (3,4) -> result=12.
